inst_fetch_ctrl: RTL



---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_buffer.sv | 77 +++++++
 rtl/inst_fetch_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared core constants and types.
// - DATA_WIDTH / INST_MEM_ADDR_WIDTH / INST_MEM_DEPTH: instruction memory geometry.
// - RESET_PC: default program counter after reset.
// - BUF_DEPTH: fetch buffer entries (fixed at 2).
// - fetch_state_e: fetch sequencer states.
//   StFault exists only when FETCH_MISALIGN_CHK_EN is defined.
// - fetch_entry_t: {pc, inst} pair held in the fetch buffer.
package core_pkg;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned INST_MEM_ADDR_WIDTH = 10;
  localparam int unsigned INST_MEM_DEPTH      = 1 << INST_MEM_ADDR_WIDTH;
  localparam int unsigned BUF_DEPTH           = 2;
  localparam logic [31:0] RESET_PC            = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    StFault = 2'd2
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry in-order FIFO of fetch_entry_t.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, push_entry_i write an entry (ignored when full)
//   pop_i                drop the head entry (ignored when empty)
//   flush_i              discard all entries; dominates push and pop
//   head_o               oldest entry (stale contents when empty)
//   full_o, empty_o      occupancy flags
//   count_o              number of valid entries (0..2)
module fetch_buffer
  import core_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [BUF_DEPTH];
  fetch_entry_t mem_d [BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: IF-stage fetch sequencer.
// Owns the PC, issues reads to a 1-cycle-latency instruction memory and queues returned
// instructions in a 2-entry buffer presented to ID under valid/ready.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect -> fault state and
// one-cycle fetch_fault_o pulse; without it redirect bits [1:0] are forced to zero).
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   fetch_en_i          level enable for issuing new reads
//   redirect_i          one-cycle flush pulse, restart at redirect_pc_i
//   redirect_pc_i       byte-address redirect target
//   imem_addr_o         word address of the read
//   imem_en_o           read strobe
//   imem_rdata_i        read data, valid the cycle after imem_en_o
//   inst_valid_o        head entry valid
//   inst_o, inst_pc_o   head instruction and its byte PC
//   fetch_fault_o       misaligned-redirect pulse (macro builds only)
//   id_ready_i          ID accepts the head
module inst_fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] ResetPc = RESET_PC
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           fetch_en_i,
  input  logic                           redirect_i,
  input  logic [31:0]                    redirect_pc_i,
  output logic [INST_MEM_ADDR_WIDTH-1:0] imem_addr_o,
  output logic                           imem_en_o,
  input  logic [DATA_WIDTH-1:0]          imem_rdata_i,
  output logic                           inst_valid_o,
  output logic [DATA_WIDTH-1:0]          inst_o,
  output logic [31:0]                    inst_pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                           fetch_fault_o,
`endif
  input  logic                           id_ready_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;
  logic         stale_q, stale_d;

  logic         pop, push, issue;
  logic [2:0]   occ, occ_after_pop;
  logic [31:0]  redirect_tgt;
  fetch_entry_t head, push_entry;
  logic         buf_full, buf_empty;
  logic [1:0]   buf_count;

`ifdef FETCH_MISALIGN_CHK_EN
  logic         redirect_misaligned;
  logic         fault_q;

  assign redirect_misaligned = redirect_i & (|redirect_pc_i[1:0]);
  assign redirect_tgt        = redirect_pc_i;
  assign fetch_fault_o       = fault_q;
`else
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign redirect_tgt        = {redirect_pc_i[31:2], 2'b00};
`endif

  assign inst_valid_o  = ~buf_empty;
  assign inst_o        = head.inst;
  assign inst_pc_o     = head.pc;
  assign pop           = inst_valid_o & id_ready_i;

  // Count the outstanding read so a stalled ID never sees more than two entries.
  assign occ           = {1'b0, buf_count} + {2'b00, inflight_q};
  assign occ_after_pop = occ - {2'b00, pop};
  assign issue         = (state_q == StFetch) & ~redirect_i & (occ_after_pop < 3'd2);

  assign imem_en_o     = issue;
  assign imem_addr_o   = pc_q[INST_MEM_ADDR_WIDTH+1:2];

  // A return is dropped if a redirect lands on it or preceded it.
  assign push          = inflight_q & ~stale_q & ~redirect_i;
  assign push_entry    = '{pc: inflight_pc_q, inst: imem_rdata_i};

  fetch_buffer u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    stale_d       = redirect_i;
    if (issue) begin
      pc_d = pc_q + 32'd4;
    end
    case (state_q)
      StIdle:  if (fetch_en_i) state_d = StFetch;
      StFetch: if (!fetch_en_i) state_d = StIdle;
`ifdef FETCH_MISALIGN_CHK_EN
      StFault: state_d = StFault;
`endif
      default: state_d = StIdle;
    endcase
    if (redirect_i) begin
      pc_d = redirect_tgt;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_misaligned) begin
        state_d = StFault;
      end else if (state_q == StFault) begin
        state_d = StFetch;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pc_q          <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      stale_q       <= stale_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= redirect_misaligned;
    end
  end
`endif

endmodule
